spi_regfile: RTL and testbench

Parametrised SPI mode-0 register-file peripheral, the next generation of the team's write-only SPI control block. It adds configurable register count, data and address width, and SPI read-back on CIPO. It also adds explicit frame-error reporting and a per-write strobe. It sits between the chip-level SPI pins and the output-enable/PWM configuration logic, which consumes its flat register bus.

---
 rtl/spi_regfile.sv | 132 +++++++++++++
 tb/tb_spi_regfile.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/spi_regfile.sv
// SPI mode-0 register file: synchronises the SPI pins into clk and decodes
// write/read frames into a parameterised bank of registers with read-back on CIPO.
module spi_regfile #(
    parameter int                NUM_REGS  = 8,
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SCLK,
    input  logic                       nCS,
    input  logic                       COPI,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_valid,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FRAME_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam int IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(1 + ADDR_W);
    localparam logic [ADDR_W:0]  ADDR_LIM = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_s1_reg, sclk_s2_reg, sclk_h_reg;
    logic ncs_s1_reg, ncs_s2_reg, ncs_h_reg;
    logic copi_s1_reg, copi_s2_reg;

    logic [FRAME_W-1:0] rx_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [DATA_W-1:0]  rd_shift_reg;
    logic [DATA_W-1:0]  regs_reg [NUM_REGS];
    logic               wr_valid_reg, frame_err_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall;
    assign sclk_rise = sclk_s2_reg & ~sclk_h_reg;
    assign sclk_fall = ~sclk_s2_reg & sclk_h_reg;
    assign ncs_rise  = ncs_s2_reg & ~ncs_h_reg;
    assign ncs_fall  = ~ncs_s2_reg & ncs_h_reg;

    // Full-frame fields (valid at nCS rise) and header fields (valid once
    // R/W plus address have been shifted in, i.e. at the read-load point).
    logic              fr_rw, hdr_rw, fr_in_range, hdr_in_range;
    logic [ADDR_W-1:0] fr_addr, hdr_addr;
    logic [DATA_W-1:0] fr_data;
    assign fr_rw        = rx_reg[FRAME_W-1];
    assign fr_addr      = rx_reg[DATA_W +: ADDR_W];
    assign fr_data      = rx_reg[DATA_W-1:0];
    assign hdr_rw       = rx_reg[ADDR_W];
    assign hdr_addr     = rx_reg[ADDR_W-1:0];
    assign fr_in_range  = {1'b0, fr_addr} < ADDR_LIM;
    assign hdr_in_range = {1'b0, hdr_addr} < ADDR_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s1_reg   <= 1'b0;
            sclk_s2_reg   <= 1'b0;
            sclk_h_reg    <= 1'b0;
            ncs_s1_reg    <= 1'b1;
            ncs_s2_reg    <= 1'b1;
            ncs_h_reg     <= 1'b1;
            copi_s1_reg   <= 1'b0;
            copi_s2_reg   <= 1'b0;
            rx_reg        <= '0;
            cnt_reg       <= '0;
            rd_shift_reg  <= '0;
            wr_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            wr_addr_reg   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= RESET_VAL;
        end else begin
            sclk_s1_reg   <= SCLK;
            sclk_s2_reg   <= sclk_s1_reg;
            sclk_h_reg    <= sclk_s2_reg;
            ncs_s1_reg    <= nCS;
            ncs_s2_reg    <= ncs_s1_reg;
            ncs_h_reg     <= ncs_s2_reg;
            copi_s1_reg   <= COPI;
            copi_s2_reg   <= copi_s1_reg;
            wr_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            // nCS edges take priority over any SCLK edge seen in the same cycle.
            if (ncs_rise) begin
                rd_shift_reg <= '0;
                if (cnt_reg == CNT_FULL) begin
                    if (fr_rw && fr_in_range) begin
                        regs_reg[fr_addr[IDX_W-1:0]] <= fr_data;
                        wr_valid_reg                 <= 1'b1;
                        wr_addr_reg                  <= fr_addr;
                    end
                end else if (cnt_reg != '0) begin
                    frame_err_reg <= 1'b1;
                end
            end else if (ncs_fall) begin
                cnt_reg      <= '0;
                rx_reg       <= '0;
                rd_shift_reg <= '0;
            end else if (!ncs_s2_reg) begin
                if (sclk_rise) begin
                    rx_reg <= {rx_reg[FRAME_W-2:0], copi_s2_reg};
                    if (cnt_reg != CNT_SAT) cnt_reg <= cnt_reg + 1'b1;
                end else if (sclk_fall) begin
                    if (cnt_reg == CNT_HDR && !hdr_rw)
                        rd_shift_reg <= hdr_in_range ? regs_reg[hdr_addr[IDX_W-1:0]] : '0;
                    else
                        rd_shift_reg <= {rd_shift_reg[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_flat
            assign regs_out[gi*DATA_W +: DATA_W] = regs_reg[gi];
        end
    endgenerate

    assign cipo_oe   = ~ncs_s2_reg;
    assign CIPO      = ~ncs_s2_reg & rd_shift_reg[DATA_W-1];
    assign wr_valid  = wr_valid_reg;
    assign wr_addr   = wr_addr_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: bit-banged SPI frames with hand-computed
// expectations for writes, read-back, out-of-range, framing errors and reset.
module tb_spi_regfile;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b0;
    logic        ncs = 1'b1;
    logic        copi = 1'b0;
    logic        cipo;
    logic        cipo_oe;
    logic [63:0] regs_out;
    logic        wr_valid;
    logic [6:0]  wr_addr;
    logic        frame_err;

    int          n_checks = 0;
    int          n_fail = 0;
    int          wv_cnt = 0;
    int          fe_cnt = 0;
    logic [6:0]  last_wr_addr = '0;
    logic [31:0] cap;
    logic        oe_mid;

    spi_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .SCLK      (sclk),
        .nCS       (ncs),
        .COPI      (copi),
        .CIPO      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge; a 2-cycle pulse counts twice.
    always @(negedge clk) begin
        if (wr_valid) begin
            wv_cnt = wv_cnt + 1;
            last_wr_addr = wr_addr;
        end
        if (frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b, inout logic [31:0] c);
        copi = b;
        wait_clk(5);
        sclk = 1'b1;
        c = {c[30:0], cipo};
        wait_clk(5);
        sclk = 1'b0;
    endtask

    // Sends the low n bits of data MSB first; returns CIPO sampled at each rise.
    task automatic frame(input logic [31:0] data, input int n,
                         output logic [31:0] c, output logic oe);
        c = '0;
        wv_cnt = 0;
        fe_cnt = 0;
        ncs = 1'b0;
        wait_clk(6);
        oe = cipo_oe;
        for (int i = n - 1; i >= 0; i--) spi_bit(data[i], c);
        wait_clk(6);
        ncs = 1'b1;
        copi = 1'b0;
        wait_clk(4);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("reset_regs", regs_out, 64'h0);
        check("reset_cipo", {63'b0, cipo}, 64'h0);
        check("reset_oe", {63'b0, cipo_oe}, 64'h0);
        check("reset_pulses", {62'b0, wr_valid, frame_err}, 64'h0);
        wait_clk(4);

        // Write 0xA5 to register 2
        frame(32'h82A5, 16, cap, oe_mid);
        check("wr_regs", regs_out, 64'h0000_0000_00A5_0000);
        wait_clk(4);
        check("wr_oe_mid", {63'b0, oe_mid}, 64'h1);
        check("wr_valid_cnt", 64'(wv_cnt), 64'd1);
        check("wr_addr", {57'b0, last_wr_addr}, 64'd2);
        check("wr_no_err", 64'(fe_cnt), 64'd0);

        // Read back register 2
        frame(32'h0200, 16, cap, oe_mid);
        wait_clk(4);
        check("rd_data", {56'b0, cap[7:0]}, 64'hA5);
        check("rd_hdr_quiet", {56'b0, cap[15:8]}, 64'h0);
        check("rd_oe_mid", {63'b0, oe_mid}, 64'h1);
        check("rd_oe_after", {63'b0, cipo_oe}, 64'h0);
        check("rd_no_write", 64'(wv_cnt), 64'd0);
        check("rd_regs", regs_out, 64'h0000_0000_00A5_0000);

        // Out-of-range write and read (addr 0x10)
        frame(32'h90FF, 16, cap, oe_mid);
        wait_clk(4);
        check("oor_regs", regs_out, 64'h0000_0000_00A5_0000);
        check("oor_no_wv", 64'(wv_cnt), 64'd0);
        check("oor_no_fe", 64'(fe_cnt), 64'd0);
        frame(32'h1000, 16, cap, oe_mid);
        wait_clk(4);
        check("oor_rd_data", {56'b0, cap[7:0]}, 64'h0);

        // Short (12-bit) frame
        frame(32'h0FFF, 12, cap, oe_mid);
        wait_clk(4);
        check("short_fe", 64'(fe_cnt), 64'd1);
        check("short_no_wv", 64'(wv_cnt), 64'd0);
        check("short_regs", regs_out, 64'h0000_0000_00A5_0000);

        // Overrun (17-bit) frame
        frame(32'h1FFFF, 17, cap, oe_mid);
        wait_clk(4);
        check("long_fe", 64'(fe_cnt), 64'd1);
        check("long_no_wv", 64'(wv_cnt), 64'd0);
        check("long_regs", regs_out, 64'h0000_0000_00A5_0000);

        // Idle CS toggle
        frame(32'h0, 0, cap, oe_mid);
        wait_clk(4);
        check("idle_no_fe", 64'(fe_cnt), 64'd0);
        check("idle_no_wv", 64'(wv_cnt), 64'd0);

        // Reset after 9 bits of 0x84FF
        wv_cnt = 0;
        fe_cnt = 0;
        cap = '0;
        ncs = 1'b0;
        wait_clk(6);
        for (int i = 15; i >= 7; i--) spi_bit(1'((32'h84FF >> i) & 1), cap);
        rst = 1'b1;
        wait_clk(2);
        ncs = 1'b1;
        copi = 1'b0;
        rst = 1'b0;
        wait_clk(8);
        check("rstmid_regs", regs_out, 64'h0);
        check("rstmid_no_wv", 64'(wv_cnt), 64'd0);
        check("rstmid_no_fe", 64'(fe_cnt), 64'd0);
        check("rstmid_oe", {63'b0, cipo_oe}, 64'h0);

        frame(32'h84FF, 16, cap, oe_mid);
        wait_clk(4);
        check("post_rst_regs", regs_out, 64'h0000_00FF_0000_0000);
        check("post_rst_wv", 64'(wv_cnt), 64'd1);
        check("post_rst_addr", {57'b0, last_wr_addr}, 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
